data_memory: RTL and testbench
==============================

DATA_MEMORY -- requirements
Module: data_memory

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: memory depth in 32-bit words; power of two, minimum 4.
REQ-002 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-004 Port mem, interface mem_read_write.mem_side: this block is the responder end of the core-side data port.
REQ-005 mem.REQ, input, 1: access request, sampled at each rising clk edge.
REQ-006 mem.WRITE_EN, input, 1: 1 = store, 0 = load.
REQ-007 mem.L_UNSIGNED, input, 1: load extension; 1 = zero-extend, 0 = sign-extend.
REQ-008 mem.N_BYTES, input, 2: access size; 00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 mem.ADDR, input, MEM_ADDR_WIDTH: byte address.
REQ-010 mem.W_DATA, input, MEM_WORD_WIDTH: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-011 mem.R_DATA, output, MEM_WORD_WIDTH: registered, extended load data.
REQ-012 mem.ADDR_ERR, output, 1: registered error flag for the access sampled on the previous edge.

Function
REQ-013 Response latency SHALL be exactly 1 cycle: a request sampled at edge N produces R_DATA/ADDR_ERR valid from edge N until edge N+1.
REQ-014 No stall or backpressure exists: a new request SHALL be accepted every cycle, including back-to-back load/store mixes.
REQ-015 Error conditions SHALL be: N_BYTES = 11; ADDR >= DEPTH_WORDS*4; or misalignment (see REQ-025).
REQ-016 Errored access: ADDR_ERR SHALL be 1 for one response cycle; memory SHALL NOT be written; R_DATA SHALL hold its previous value.
REQ-017 Valid store: only the addressed byte lanes SHALL be written at the sampling edge. Lanes follow little-endian order: byte lane = ADDR[1:0]; half lanes = ADDR[1]*2 and ADDR[1]*2+1.
REQ-018 Store response: ADDR_ERR SHALL be 0 and R_DATA SHALL hold its previous value.
REQ-019 Valid load: R_DATA SHALL be the addressed byte, half or word, shifted to the LSBs and extended per L_UNSIGNED. Word loads SHALL ignore L_UNSIGNED.
REQ-020 Idle cycle (REQ = 0): ADDR_ERR SHALL be 0 next cycle; R_DATA SHALL hold its value.
REQ-021 A load sampled on the edge after a store to the same word SHALL return the newly written data (write-first, no forwarding hazard).
REQ-022 The final word (ADDR = DEPTH_WORDS*4-4) SHALL be accessible. Address DEPTH_WORDS*4 SHALL error; it SHALL NOT wrap to word 0.

Reset
REQ-023 While rst_n = 0: R_DATA = 0 and ADDR_ERR = 0 immediately, and no writes occur.
REQ-024 Memory array contents SHALL NOT be reset. A request in flight when rst_n asserts SHALL be discarded; the first response after deassertion comes from the first edge with rst_n = 1.

Configuration
REQ-025 Macro DMEM_ALIGN_CHECK_EN:
- Defined: misaligned half (ADDR[0] = 1) or word (ADDR[1:0] != 0) access SHALL raise ADDR_ERR with no write.
- Undefined: the low address bits SHALL be forced to alignment (half clears ADDR[0], word clears ADDR[1:0]) and the access completes normally. Range and size errors still apply.

Structure
REQ-026 memory_pkg SHALL hold:
- enum mem_size_e (BYTE = 00, HALF = 01, WORD = 10, RSVD = 11);
- MEM_ADDR_WIDTH and MEM_WORD_WIDTH (32);
- function byte-enable mask from size and offset.
REQ-027 Combinational sub-module mem_load_align SHALL do lane select plus sign/zero extension. data_memory SHALL own the array, error logic and registers.

Verification
REQ-028 Store word 0xDEADBEEF at 0x10, then load word at 0x10 -> R_DATA = 0xDEADBEEF, ADDR_ERR = 0, one cycle after the load request.
REQ-029 With 0x10 holding 0xDEADBEEF, load byte signed at 0x13 -> 0xFFFFFFDE; load byte unsigned at 0x13 -> 0x000000DE; load half signed at 0x10 -> 0xFFFFBEEF.
REQ-030 Store byte 0x55 at 0x11 over 0xDEADBEEF -> word load returns 0xDEAD55EF; other lanes untouched.
REQ-031 Load word at 0x12 -> with DMEM_ALIGN_CHECK_EN: ADDR_ERR = 1 and R_DATA unchanged; without it: returns the word at 0x10. Store with N_BYTES = 11 -> ADDR_ERR = 1 and no write.
REQ-032 DEPTH_WORDS = 1024, load at 0xFFC -> ADDR_ERR = 0; store at 0x1000 -> ADDR_ERR = 1 and word 0 unchanged.
REQ-033 Assert rst_n low mid-stream during back-to-back requests -> R_DATA = 0 and ADDR_ERR = 0 asynchronously; array contents retained; the next load after release returns the stored data.

Source files
------------

// File: rtl/memory_pkg.sv
// Shared types, widths and byte-enable helper for the core-side data memory port.
package memory_pkg;

   localparam int MEM_ADDR_WIDTH = 32;
   localparam int MEM_WORD_WIDTH = 32;

   typedef enum logic [1:0] {
      BYTE = 2'b00,
      HALF = 2'b01,
      WORD = 2'b10,
      RSVD = 2'b11
   } mem_size_e;

   // Little-endian lane mask; the reserved size enables nothing.
   function automatic logic [3:0] byte_en(input mem_size_e size, input logic [1:0] off);
      case (size)
         BYTE:    byte_en = 4'b0001 << off;
         HALF:    byte_en = off[1] ? 4'b1100 : 4'b0011;
         WORD:    byte_en = 4'b1111;
         default: byte_en = 4'b0000;
      endcase
   endfunction

endpackage

// File: rtl/mem_read_write.sv
// Core-side data port bundle; mem_side is the responder (memory) end.
interface mem_read_write;
   import memory_pkg::*;

   logic                      REQ;
   logic                      WRITE_EN;
   logic                      L_UNSIGNED;
   logic [1:0]                N_BYTES;
   logic [MEM_ADDR_WIDTH-1:0] ADDR;
   logic [MEM_WORD_WIDTH-1:0] W_DATA;
   logic [MEM_WORD_WIDTH-1:0] R_DATA;
   logic                      ADDR_ERR;

   modport mem_side (
      input  REQ, WRITE_EN, L_UNSIGNED, N_BYTES, ADDR, W_DATA,
      output R_DATA, ADDR_ERR
   );

   modport core_side (
      output REQ, WRITE_EN, L_UNSIGNED, N_BYTES, ADDR, W_DATA,
      input  R_DATA, ADDR_ERR
   );

endinterface

// File: rtl/mem_load_align.sv
// Load lane select plus sign/zero extension (purely combinational).
module mem_load_align
   import memory_pkg::*;
(
   input  logic [MEM_WORD_WIDTH-1:0] word_i,
   input  mem_size_e                 size_i,
   input  logic [1:0]                off_i,
   input  logic                      unsigned_i,
   output logic [MEM_WORD_WIDTH-1:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = word_i[{off_i, 3'b000} +: 8];
      half_sel = off_i[1] ? word_i[31:16] : word_i[15:0];
      case (size_i)
         BYTE:    data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
         HALF:    data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
         WORD:    data_o = word_i;
         default: data_o = '0;
      endcase
   end

endmodule

// File: rtl/data_memory.sv
// Single-cycle data memory with byte/half/word access and registered response.
// Build option: DMEM_ALIGN_CHECK_EN (misaligned access errors instead of being force-aligned).
module data_memory
   import memory_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024
) (
   input logic         clk,
   input logic         rst_n,
   mem_read_write.mem_side mem
);

   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [MEM_ADDR_WIDTH-1:0] ADDR_LIMIT = MEM_ADDR_WIDTH'(DEPTH_WORDS * 4);

   logic [MEM_WORD_WIDTH-1:0] mem_q [DEPTH_WORDS];
   logic [MEM_WORD_WIDTH-1:0] r_data_q, r_data_d;
   logic                      addr_err_q, addr_err_d;

   mem_size_e                 size;
   logic [MEM_ADDR_WIDTH-1:0] addr_eff;
   logic [1:0]                off;
   logic [IDX_W-1:0]          idx;
   logic                      misalign, err, wr, rd;
   logic [3:0]                be;
   logic [MEM_WORD_WIDTH-1:0] w_lanes, rd_word, ld_data;

   assign size = mem_size_e'(mem.N_BYTES);

   always_comb begin
      addr_eff = mem.ADDR;
      misalign = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
      misalign = ((size == HALF) && mem.ADDR[0]) ||
                 ((size == WORD) && (mem.ADDR[1:0] != 2'b00));
`else
      if (size == HALF)      addr_eff[0]   = 1'b0;
      else if (size == WORD) addr_eff[1:0] = 2'b00;
`endif
   end

   // Limit is a word multiple, so forcing alignment never changes the range verdict.
   assign off = addr_eff[1:0];
   assign idx = addr_eff[IDX_W+1:2];
   assign err = mem.REQ && ((size == RSVD) || (addr_eff >= ADDR_LIMIT) || misalign);
   assign wr  = mem.REQ && mem.WRITE_EN && !err;
   assign rd  = mem.REQ && !mem.WRITE_EN && !err;
   assign be  = byte_en(size, off);

   always_comb begin
      case (size)
         BYTE:    w_lanes = {4{mem.W_DATA[7:0]}};
         HALF:    w_lanes = {2{mem.W_DATA[15:0]}};
         default: w_lanes = mem.W_DATA;
      endcase
   end

   assign rd_word = mem_q[idx];

   mem_load_align u_load_align (
      .word_i     (rd_word),
      .size_i     (size),
      .off_i      (off),
      .unsigned_i (mem.L_UNSIGNED),
      .data_o     (ld_data)
   );

   assign r_data_d   = rd ? ld_data : r_data_q;
   assign addr_err_d = err;

   // Array shares the reset process only so that reset blocks writes; its contents are never cleared.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_q   <= '0;
         addr_err_q <= 1'b0;
      end else begin
         r_data_q   <= r_data_d;
         addr_err_q <= addr_err_d;
         if (wr) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i]) mem_q[idx][8*i +: 8] <= w_lanes[8*i +: 8];
            end
         end
      end
   end

   assign mem.R_DATA   = r_data_q;
   assign mem.ADDR_ERR = addr_err_q;

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed requests queue expected responses, a monitor checks them.
module tb_data_memory;
   import memory_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   mem_read_write bus ();

   data_memory #(.DEPTH_WORDS(1024)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .mem   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] id;
      logic        err;
      logic [31:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   vec_id = 0;

`ifdef DMEM_ALIGN_CHECK_EN
   localparam logic [31:0] W12_D   = 32'hDEAD55EF;
   localparam logic        W12_E   = 1'b1;
   localparam logic [31:0] HMIS_D  = 32'h0BADF00D;
   localparam logic        HMIS_E  = 1'b1;
`else
   localparam logic [31:0] W12_D   = 32'hDEAD55EF;
   localparam logic        W12_E   = 1'b0;
   localparam logic [31:0] HMIS_D  = 32'hFFFFF00D;
   localparam logic        HMIS_E  = 1'b0;
`endif

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, want);
      end
   endtask

   task automatic issue(input logic we, input logic uns, input logic [1:0] nb,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] ed, input logic ee);
      @(negedge clk);
      bus.REQ        = 1'b1;
      bus.WRITE_EN   = we;
      bus.L_UNSIGNED = uns;
      bus.N_BYTES    = nb;
      bus.ADDR       = addr;
      bus.W_DATA     = wd;
      exp_q.push_back('{vec_id, ee, ed});
      vec_id++;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.REQ = 1'b0;
      end
   endtask

   // Monitor: every request sampled with reset released owes exactly one response.
   always @(posedge clk) begin
      logic sampled;
      exp_t e;
      sampled = bus.REQ && rst_n;
      #1;
      if (sampled) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resp: got data=%h err=%b, expected no response", bus.R_DATA, bus.ADDR_ERR);
         end else begin
            e = exp_q.pop_front();
            check($sformatf("resp%0d_data", e.id), bus.R_DATA, e.data);
            check($sformatf("resp%0d_err", e.id), {31'b0, bus.ADDR_ERR}, {31'b0, e.err});
         end
      end else if (rst_n) begin
         check("idle_err", {31'b0, bus.ADDR_ERR}, 32'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected finish");
      $fatal(1);
   end

   initial begin
      bus.REQ = 1'b0; bus.WRITE_EN = 1'b0; bus.L_UNSIGNED = 1'b0;
      bus.N_BYTES = 2'b00; bus.ADDR = '0; bus.W_DATA = '0;
      #1 rst_n = 1'b0;
      #1;
      check("reset_rdata", bus.R_DATA, 32'h0);
      check("reset_err", {31'b0, bus.ADDR_ERR}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      //     we    uns   nb     addr          wdata          exp data       exp err
      issue(1'b1, 1'b0, 2'b10, 32'h0000_0000, 32'h0BADF00D, 32'h00000000, 1'b0);
      issue(1'b1, 1'b0, 2'b10, 32'h0000_0010, 32'hDEADBEEF, 32'h00000000, 1'b0);
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0);
      issue(1'b0, 1'b0, 2'b00, 32'h0000_0013, 32'h0,        32'hFFFFFFDE, 1'b0);
      issue(1'b0, 1'b1, 2'b00, 32'h0000_0013, 32'h0,        32'h000000DE, 1'b0);
      issue(1'b0, 1'b0, 2'b01, 32'h0000_0010, 32'h0,        32'hFFFFBEEF, 1'b0);
      issue(1'b0, 1'b1, 2'b01, 32'h0000_0012, 32'h0,        32'h0000DEAD, 1'b0);
      issue(1'b1, 1'b0, 2'b00, 32'h0000_0011, 32'hAAAAAA55, 32'h0000DEAD, 1'b0);
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,        32'hDEAD55EF, 1'b0);
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0012, 32'h0,        W12_D,        W12_E);
      issue(1'b1, 1'b0, 2'b11, 32'h0000_0010, 32'h00000000, W12_D,        1'b1);
      issue(1'b0, 1'b1, 2'b10, 32'h0000_0010, 32'h0,        32'hDEAD55EF, 1'b0);
      issue(1'b1, 1'b0, 2'b10, 32'h0000_0FFC, 32'h12345678, 32'hDEAD55EF, 1'b0);
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0FFC, 32'h0,        32'h12345678, 1'b0);
      issue(1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'hCAFEF00D, 32'h12345678, 1'b1);
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0000, 32'h0,        32'h0BADF00D, 1'b0);
      issue(1'b0, 1'b0, 2'b01, 32'h0000_0001, 32'h0,        HMIS_D,       HMIS_E);
      issue(1'b0, 1'b1, 2'b00, 32'h0000_1000, 32'h0,        HMIS_D,       1'b1);
      idle(2);
      issue(1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h11223344, HMIS_D,       1'b0);
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0020, 32'h0,        32'h11223344, 1'b0);

      // Reset lands mid-cycle while a load is in flight; that load is discarded.
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,        32'hDEAD55EF, 1'b0);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      check("midreset_rdata", bus.R_DATA, 32'h0);
      check("midreset_err", {31'b0, bus.ADDR_ERR}, 32'h0);
      repeat (2) begin
         @(negedge clk);
         bus.REQ = 1'b1; bus.WRITE_EN = 1'b1; bus.N_BYTES = 2'b10;
         bus.ADDR = 32'h0000_0020; bus.W_DATA = 32'hFFFFFFFF;
      end
      #1;
      check("held_reset_rdata", bus.R_DATA, 32'h0);
      @(negedge clk);
      bus.REQ = 1'b0;
      rst_n = 1'b1;

      issue(1'b0, 1'b0, 2'b10, 32'h0000_0020, 32'h0,        32'h11223344, 1'b0);
      issue(1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,        32'hDEAD55EF, 1'b0);
      idle(3);
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
